// File: rtl/disk_write_arbiter_pkg.sv
// Shared types and constants for the disk write-port arbiter.
package disk_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 12;
    localparam int ADDR_W  = 8;
    localparam int EN_W    = 3;

    localparam int REQ_NORMAL = 0;
    localparam int REQ_READ   = 1;
    localparam int REQ_RAID   = 2;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        if (idx < 2'(NUM_REQ)) v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pointer advance, wrapping modulo NUM_REQ.
    function automatic logic [1:0] next_ptr(input logic [1:0] idx);
        return (idx >= 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/disk_write_arbiter_picker.sv
// Combinational 3-way selector: round-robin from ptr (mode 0) or fixed priority 0 > 1 > 2 (mode 1).
module rr_picker3
    import disk_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       mode,
    output logic [2:0] gnt,
    output logic [1:0] gnt_idx
);

    always_comb begin
        logic       found;
        logic [2:0] start;
        logic [2:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        start   = mode ? 3'd0 : {1'b0, ptr};
        if (start >= 3'(NUM_REQ)) start = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = start + 3'(k);
            if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
            if (!found && req[cand[1:0]]) begin
                found              = 1'b1;
                gnt[cand[1:0]]     = 1'b1;
                gnt_idx            = cand[1:0];
            end
        end
    end

endmodule

// File: rtl/disk_write_arbiter.sv
// Arbitrates three requesters onto the single disk write port.
// Optional ack timeout enabled by defining DISK_WR_TIMEOUT_EN.
module disk_write_arbiter
    import disk_arb_pkg::*;
#(
    parameter int PRIO_MODE   = 0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wr_disk_0,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wr_disk_1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wr_disk_2,
    input  logic [NUM_REQ*EN_W-1:0]     req_en_wr_mem,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [NUM_REQ-1:0]          req_err,
    input  logic                        out_valid_wr,
    output logic [DATA_W-1:0]           wr_disk_0,
    output logic [DATA_W-1:0]           wr_disk_1,
    output logic [DATA_W-1:0]           wr_disk_2,
    output logic [EN_W-1:0]             en_wr_mem,
    output logic [ADDR_W-1:0]           address,
    output logic                        wr_valid,
    output logic                        busy
);

    localparam logic PRIO_FIXED = (PRIO_MODE != 0);

    logic [DATA_W-1:0] d0_arr [NUM_REQ];
    logic [DATA_W-1:0] d1_arr [NUM_REQ];
    logic [DATA_W-1:0] d2_arr [NUM_REQ];
    logic [EN_W-1:0]   en_arr [NUM_REQ];
    logic [ADDR_W-1:0] ad_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign d0_arr[gi] = req_wr_disk_0[gi*DATA_W +: DATA_W];
        assign d1_arr[gi] = req_wr_disk_1[gi*DATA_W +: DATA_W];
        assign d2_arr[gi] = req_wr_disk_2[gi*DATA_W +: DATA_W];
        assign en_arr[gi] = req_en_wr_mem[gi*EN_W +: EN_W];
        assign ad_arr[gi] = req_address[gi*ADDR_W +: ADDR_W];
    end

    arb_state_t        state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        owner_q, owner_d;
    logic [DATA_W-1:0] wr_disk_0_q, wr_disk_0_d;
    logic [DATA_W-1:0] wr_disk_1_q, wr_disk_1_d;
    logic [DATA_W-1:0] wr_disk_2_q, wr_disk_2_d;
    logic [EN_W-1:0]   en_wr_mem_q, en_wr_mem_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              wr_valid_q, wr_valid_d;
    logic              busy_q, busy_d;
    logic [2:0]        req_ready_q, req_ready_d;
    logic [2:0]        req_done_q, req_done_d;

    logic [2:0] gnt;
    logic [1:0] gnt_idx;

    rr_picker3 u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .mode    (PRIO_FIXED),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

`ifdef DISK_WR_TIMEOUT_EN
    localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
    logic       timed_out_q, timed_out_d;
    logic [2:0] req_err_q, req_err_d;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(ACK_TIMEOUT);
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        wr_disk_0_d = wr_disk_0_q;
        wr_disk_1_d = wr_disk_1_q;
        wr_disk_2_d = wr_disk_2_q;
        en_wr_mem_d = en_wr_mem_q;
        address_d   = address_q;
        wr_valid_d  = wr_valid_q;
        req_ready_d = '0;
        req_done_d  = '0;
`ifdef DISK_WR_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        req_err_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d     = gnt_idx;
                    wr_disk_0_d = d0_arr[gnt_idx];
                    wr_disk_1_d = d1_arr[gnt_idx];
                    wr_disk_2_d = d2_arr[gnt_idx];
                    en_wr_mem_d = en_arr[gnt_idx];
                    address_d   = ad_arr[gnt_idx];
                    req_ready_d = gnt;
`ifdef DISK_WR_TIMEOUT_EN
                    timed_out_d = 1'b0;
`endif
                    // A write with no lanes enabled never touches memory.
                    state_d = (en_arr[gnt_idx] == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                wr_valid_d = 1'b1;
                state_d    = WAIT_ACK;
`ifdef DISK_WR_TIMEOUT_EN
                cnt_d      = '0;
`endif
            end
            WAIT_ACK: begin
                if (out_valid_wr) begin
                    wr_valid_d = 1'b0;
                    state_d    = DONE;
                end
`ifdef DISK_WR_TIMEOUT_EN
                else if (cnt_q + 8'd1 == ACK_LIMIT) begin
                    wr_valid_d  = 1'b0;
                    state_d     = DONE;
                    timed_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE: begin
                req_done_d  = req_onehot(owner_q);
`ifdef DISK_WR_TIMEOUT_EN
                req_err_d   = timed_out_q ? req_onehot(owner_q) : '0;
`endif
                wr_disk_0_d = '0;
                wr_disk_1_d = '0;
                wr_disk_2_d = '0;
                en_wr_mem_d = '0;
                address_d   = '0;
                rr_ptr_d    = next_ptr(owner_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            wr_disk_0_q <= '0;
            wr_disk_1_q <= '0;
            wr_disk_2_q <= '0;
            en_wr_mem_q <= '0;
            address_q   <= '0;
            wr_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= '0;
            req_done_q  <= '0;
`ifdef DISK_WR_TIMEOUT_EN
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            req_err_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            wr_disk_0_q <= wr_disk_0_d;
            wr_disk_1_q <= wr_disk_1_d;
            wr_disk_2_q <= wr_disk_2_d;
            en_wr_mem_q <= en_wr_mem_d;
            address_q   <= address_d;
            wr_valid_q  <= wr_valid_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            req_done_q  <= req_done_d;
`ifdef DISK_WR_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            req_err_q   <= req_err_d;
`endif
        end
    end

`ifdef DISK_WR_TIMEOUT_EN
    assign req_err = req_err_q;
`else
    assign req_err = '0;
`endif

    assign req_ready = req_ready_q;
    assign req_done  = req_done_q;
    assign wr_disk_0 = wr_disk_0_q;
    assign wr_disk_1 = wr_disk_1_q;
    assign wr_disk_2 = wr_disk_2_q;
    assign en_wr_mem = en_wr_mem_q;
    assign address   = address_q;
    assign wr_valid  = wr_valid_q;
    assign busy      = busy_q;

endmodule

// File: doc/disk_write_arbiter.md
Name: disk_write_arbiter

Overview:
- Shares the single disk write port (three 12-bit Hamming-encoded disk lanes, 3-bit enable, 8-bit address) among three requesters: 0 = normal write, 1 = read write-back (corrected data), 2 = RAID rebuild.
- Selects a requester, latches its payload, drives the port, waits for the memory done strobe, then returns a one-cycle done pulse to the owning requester.
- Sits between the write/read/RAID sub-blocks and the disk memory wrapper.

Parameters:
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (0 > 1 > 2).
- ACK_TIMEOUT, 255, cycles to wait for out_valid_wr before abort; used only with the optional feature; range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  3  bit i = requester i has a pending write; held until req_ready[i]
- req_wr_disk_0  in  36  disk-0 lane, 12 bits per requester, requester i at [12i+11:12i]
- req_wr_disk_1  in  36  disk-1 lane, same packing
- req_wr_disk_2  in  36  disk-2 lane, same packing
- req_en_wr_mem  in  9  3-bit enable per requester, requester i at [3i+2:3i]
- req_address  in  24  8-bit address per requester, requester i at [8i+7:8i]
- req_ready  out  3  one-cycle pulse: payload of requester i captured
- req_done  out  3  one-cycle pulse: requester i's write completed
- req_err  out  3  one-cycle pulse with req_done: write aborted (optional feature)
- out_valid_wr  in  1  memory done strobe
- wr_disk_0, wr_disk_1, wr_disk_2  out  12 each  lane data to memory
- en_wr_mem  out  3  lane enables
- address  out  8  write address
- wr_valid  out  1  write command valid
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-low. All outputs and state are registered.
- Reset values: all outputs 0; FSM = IDLE; rr_ptr = 0; timeout counter = 0.
- Reset mid-operation: the in-flight write is dropped. No req_done is issued, and wr_valid is 0 on the next edge.
- States: IDLE, ISSUE, WAIT_ACK, DONE.

IDLE:
- If req_valid != 0, select winner w.
- Round-robin: first set bit scanning from rr_ptr upward, mod 3.
- Fixed priority: lowest set index.
- At the same edge: latch w's payload into the output registers, pulse req_ready[w], go to ISSUE.
- If w's en_wr_mem == 0: skip memory, go directly to DONE; wr_valid stays 0.

ISSUE:
- wr_valid = 1 with latched payload; go to WAIT_ACK.
- Latency: req_valid sampled at edge N, wr_valid high after edge N+1.

WAIT_ACK:
- wr_valid and payload held stable.
- On out_valid_wr = 1: wr_valid <= 0, go to DONE.
- An out_valid_wr in IDLE, ISSUE or DONE is ignored.

DONE:
- Pulse req_done[w] for one cycle.
- Clear wr_disk_*, en_wr_mem and address to 0.
- rr_ptr <= (w+1) mod 3; go to IDLE.
- Minimum cycle between consecutive grants is 4 clocks when the ack is immediate.

Other rules:
- Simultaneous requests: exactly one grant per transaction. Losers keep req_valid high; a loser is not granted while busy.
- Requester withdrawal: dropping req_valid after req_ready has no effect on the in-flight write.
- busy = (state != IDLE).
- req_ready, req_done and req_err are always one-hot or zero.

Optional Feature:
- Macro: DISK_WR_TIMEOUT_EN.
- Defined: an 8-bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle. When it reaches ACK_TIMEOUT without out_valid_wr: wr_valid <= 0, go to DONE, and pulse req_err[w] together with req_done[w].
- Undefined: WAIT_ACK waits indefinitely; req_err is tied to 0 and no counter is built.

Decomposition:
- Package disk_arb_pkg:
  - state enum arb_state_t (IDLE, ISSUE, WAIT_ACK, DONE).
  - Localparams NUM_REQ = 3, DATA_W = 12, ADDR_W = 8, EN_W = 3.
  - Requester index constants REQ_NORMAL = 0, REQ_READ = 1, REQ_RAID = 2.
- Sub-module rr_picker3: combinational 3-way round-robin/fixed selector. Inputs req[2:0], ptr[1:0], mode. Outputs one-hot gnt[2:0] and gnt_idx[1:0]. Instantiated once.

Test Plan:
- Single write: req_valid = 3'b001, addr 0x1A, en 3'b111, lanes 0xABC/0x123/0x456 -> req_ready[0] at N+1; wr_valid high from N+2 with exact payload; ack 3 cycles later -> req_done[0] pulse, outputs return to 0.
- Contention, round-robin: req_valid = 3'b111 held, ack immediate -> grant order 0, 1, 2, 0. Fixed priority: 0 is always granted while req_valid[0] is held.
- Zero enable: requester 2 with en 3'b000 -> req_ready[2], wr_valid never rises, req_done[2] two cycles later.
- Spurious ack: out_valid_wr pulsed in IDLE and in ISSUE -> no state change; the transaction still waits for an ack in WAIT_ACK.
- Reset mid-write: reset low during WAIT_ACK -> next edge all outputs 0, no req_done; after release, a pending req_valid = 3'b010 is granted to requester 1.
- Timeout (DISK_WR_TIMEOUT_EN defined, ACK_TIMEOUT = 4): no ack -> wr_valid drops after 4 WAIT_ACK cycles, req_done[1] and req_err[1] pulse together. Without the macro, wr_valid stays high for more than 300 cycles.
